dmem_ctrl: RTL and testbench

- Parametrised successor to the single-cycle data memory: a byte-addressed RV32 load/store data memory behind a valid/ready request port and a registered response port.
- Adds load formatting (LB/LBU/LH/LHU/LW), store lane steering, misalignment error reporting, configurable read latency and a post-reset hardware scrub that fills memory with a known pattern.
- Sits between the MEM stage and the storage array; the pipeline stalls on `req_ready` low and waits for `rsp_valid`.

---
 rtl/dmem_ctrl.sv | 156 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// RV32 byte-addressed data memory with valid/ready requests, load formatting,
// store lane steering, misalignment errors, configurable read latency and post-reset scrub.
module dmem_ctrl #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned READ_LAT = 1,
    parameter logic [31:0] INIT_VAL = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned DEPTH    = 2 ** (ADDR_W - 2);
    localparam int unsigned IW       = ADDR_W - 2;
    localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 2);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [1:0]    lat_q, lat_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [31:0]   rword_q, rword_d;

    logic [31:0]   mem [DEPTH];

    logic          req_err;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [IW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    assign req_err = (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wr_d      = wr_q;
        err_d     = err_q;
        rword_d   = rword_q;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_idx   = req_addr[ADDR_W-1:2];
        mem_wdata = '0;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_be    = '1;
                mem_idx   = cnt_q;
                mem_wdata = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wr_d    = req_wr;
                    err_d   = req_err;
                    lat_d   = '0;
                    // Load word captured at the accept edge; store commits on the same edge.
                    rword_d = mem[req_addr[ADDR_W-1:2]];
                    if (req_wr && !req_err) begin
                        mem_we    = 1'b1;
                        mem_wdata = req_wdata << {req_addr[1:0], 3'b000};
                        case (req_size)
                            2'd0:    mem_be = 4'b0001 << req_addr[1:0];
                            2'd1:    mem_be = 4'b0011 << req_addr[1:0];
                            default: mem_be = 4'b1111;
                        endcase
                    end
                    state_d = (READ_LAT > 1) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) state_d = ST_RESP;
                else                   lat_d   = lat_q + 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            lat_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rword_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rword_q <= rword_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        shifted   = rword_q >> {off_q, 3'b000};
        load_data = '0;
        case (size_q)
            2'd0:    load_data = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            2'd2:    load_data = shifted;
            default: load_data = '0;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign init_busy = (state_q == ST_INIT);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised self-checking bench for dmem_ctrl against a byte-array memory model.
module tb_dmem_ctrl;

    localparam int unsigned AW       = 6;
    localparam int unsigned LAT      = 3;
    localparam int unsigned DEPTH    = 2 ** (AW - 2);
    localparam int unsigned NBYTES   = 2 ** AW;
    localparam logic [31:0] INIT_PAT = 32'hDEADBEEF;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mbytes [NBYTES];

    dmem_ctrl #(
        .ADDR_W   (AW),
        .READ_LAT (LAT),
        .INIT_VAL (INIT_PAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_busy    (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic mdl_err(input logic [AW-1:0] a, input logic [1:0] sz);
        int unsigned n;
        n = 1 << sz;
        return (sz == 2'd3) || ((int'(a) % n) != 0);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [AW-1:0] a, input logic [1:0] sz,
                                             input logic uns);
        int unsigned n;
        logic [31:0] v;
        n = 1 << sz;
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(mbytes[int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
        return v;
    endfunction

    task automatic mdl_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int unsigned n;
        n = 1 << sz;
        for (int unsigned i = 0; i < n; i++) mbytes[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic mdl_scrub();
        logic [31:0] pat;
        pat = INIT_PAT;
        for (int unsigned w = 0; w < DEPTH; w++)
            for (int unsigned i = 0; i < 4; i++) mbytes[4*w + i] = pat[8*i +: 8];
    endtask

    // Holds reset, checks reset outputs, then releases it with a store pending to
    // confirm requests are ignored while scrubbing.
    task automatic reset_and_scrub();
        int edges;
        logic done;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_valid", 32'(rsp_valid), 32'd0);
            check("rst_err",   32'(rsp_err),   32'd0);
            check("rst_rdata", rsp_rdata,      32'd0);
            check("rst_busy",  32'(init_busy), 32'd1);
        end
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = '0;
        req_size  = 2'd2;
        req_wdata = 32'h0;
        rst       = 1'b1;
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (!init_busy) done = 1'b1;
            else begin
                check("scrub_ready", 32'(req_ready), 32'd0);
                check("scrub_valid", 32'(rsp_valid), 32'd0);
            end
        end
        req_valid = 1'b0;
        check("scrub_len", 32'(edges), 32'(DEPTH));
        mdl_scrub();
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_wr       = wr;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        exp_e = mdl_err(a, sz);
        exp_d = '0;
        if (!exp_e) begin
            if (wr) mdl_store(a, sz, wd);
            else    exp_d = mdl_load(a, sz, uns);
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_wr       = 1'($urandom);
        req_addr     = AW'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        for (int i = 0; i < int'(LAT) - 1; i++) begin
            @(negedge clk);
            check("lat_no_valid",  32'(rsp_valid), 32'd0);
            check("lat_ready_low", 32'(req_ready), 32'd0);
            check("lat_rdata_0",   rsp_rdata,      32'd0);
        end
        @(negedge clk);
        check("rsp_valid",     32'(rsp_valid), 32'd1);
        check("rsp_ready_low", 32'(req_ready), 32'd0);
        check("rsp_rdata",     rsp_rdata,      exp_d);
        check("rsp_err",       32'(rsp_err),   32'(exp_e));
        got_d = rsp_rdata;
        got_e = rsp_err;
        @(negedge clk);
        check("rsp_pulse",   32'(rsp_valid), 32'd0);
        check("ready_back",  32'(req_ready), 32'd1);
        check("idle_rdata0", rsp_rdata,      32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [1:0]  sz;
        logic [AW-1:0] a;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;

        reset_and_scrub();

        do_req(1'b0, 6'h00, 2'd2, 1'b0, 32'h0, d, e);
        check("plan_lw00", d, 32'hDEADBEEF);
        do_req(1'b0, 6'h3C, 2'd2, 1'b0, 32'h0, d, e);
        check("plan_lw3c", d, 32'hDEADBEEF);
        check("plan_lw3c_err", 32'(e), 32'd0);
        do_req(1'b1, 6'h05, 2'd0, 1'b0, 32'h80, d, e);
        do_req(1'b0, 6'h04, 2'd2, 1'b0, 32'h0, d, e);
        check("plan_sb_lw", d, 32'hDEAD80EF);
        do_req(1'b0, 6'h05, 2'd0, 1'b0, 32'h0, d, e);
        check("plan_lb", d, 32'hFFFFFF80);
        do_req(1'b0, 6'h05, 2'd0, 1'b1, 32'h0, d, e);
        check("plan_lbu", d, 32'h00000080);
        do_req(1'b1, 6'h0A, 2'd1, 1'b0, 32'h1234, d, e);
        do_req(1'b0, 6'h08, 2'd2, 1'b0, 32'h0, d, e);
        check("plan_sh_lw", d, 32'h1234BEEF);
        do_req(1'b0, 6'h0A, 2'd1, 1'b0, 32'h0, d, e);
        check("plan_lh", d, 32'h00001234);
        do_req(1'b1, 6'h0B, 2'd1, 1'b0, 32'hFFFF, d, e);
        check("plan_sh_mis", 32'(e), 32'd1);
        do_req(1'b0, 6'h02, 2'd2, 1'b0, 32'h0, d, e);
        check("plan_lw_mis", 32'(e), 32'd1);
        check("plan_lw_mis_d", d, 32'd0);
        do_req(1'b0, 6'h08, 2'd3, 1'b0, 32'h0, d, e);
        check("plan_sz3", 32'(e), 32'd1);
        do_req(1'b0, 6'h08, 2'd2, 1'b0, 32'h0, d, e);
        check("plan_lw_kept", d, 32'h1234BEEF);

        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = AW'($urandom);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~AW'((1 << sz) - 1);
            do_req(1'($urandom), a, sz, 1'($urandom), $urandom, d, e);
        end

        // Store accepted, then reset lands while the response is still pending.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 6'h0C;
        req_size  = 2'd2;
        req_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy",  32'(init_busy), 32'd1);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        reset_and_scrub();
        for (int w = 0; w < int'(DEPTH); w++) begin
            do_req(1'b0, AW'(4 * w), 2'd2, 1'b0, 32'h0, d, e);
            check("rescrub_word", d, 32'hDEADBEEF);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
